// File: rtl/pc_branch_unit.sv
// Fetch-address / branch-resolution unit. It holds the fetch PC and the execute slot,
// resolves conditional branches, and keeps the link register and saturating branch statistics.
module pc_branch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        F,
    input  logic        br_req,
    input  logic        br_link,
    input  logic [15:0] br_imm,
    input  logic        stall,
    input  logic        halt,
    output logic [15:0] pc,
    output logic [15:0] ex_pc,
    output logic        ex_valid,
    output logic        flush,
    output logic [15:0] lr,
    output logic [7:0]  br_total,
    output logic [7:0]  br_taken,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [15:0] pc_n, ex_pc_n, lr_n;
    logic        ex_valid_n, flush_n;
    logic [7:0]  br_total_n, br_taken_n;
    logic [7:0]  total_inc, taken_inc;

    // Counters stick at 8'hFF rather than wrapping.
    assign total_inc = (br_total == 8'hFF) ? br_total : br_total + 8'd1;
    assign taken_inc = (br_taken == 8'hFF) ? br_taken : br_taken + 8'd1;

    assign fsm_state = state;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ex_pc_n    = ex_pc;
        ex_valid_n = ex_valid;
        flush_n    = 1'b0;
        lr_n       = lr;
        br_total_n = br_total;
        br_taken_n = br_taken;

        if (halt) begin
            state_n    = HALT;
            ex_valid_n = 1'b0;
        end else if (!stall) begin
            case (state)
                RUN: begin
                    if (ex_valid && br_req) begin
                        br_total_n = total_inc;
                        if (F) begin
                            br_taken_n = taken_inc;
                            pc_n       = ex_pc + br_imm;
                            ex_valid_n = 1'b0;
                            flush_n    = 1'b1;
                            state_n    = FLUSH;
                            if (br_link) lr_n = ex_pc + 16'd1;
                        end else begin
                            pc_n       = pc + 16'd1;
                            ex_pc_n    = pc;
                            ex_valid_n = 1'b1;
                        end
                    end else begin
                        pc_n       = pc + 16'd1;
                        ex_pc_n    = pc;
                        ex_valid_n = 1'b1;
                    end
                end
                FLUSH: begin
                    // The squashed slot refills with the branch target already sitting on pc.
                    pc_n       = pc + 16'd1;
                    ex_pc_n    = pc;
                    ex_valid_n = 1'b1;
                    state_n    = RUN;
                end
                HALT: begin
                    ex_valid_n = 1'b0;
                end
                default: begin
                    state_n = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pc       <= RESET_PC;
            ex_pc    <= 16'h0000;
            ex_valid <= 1'b0;
            flush    <= 1'b0;
            lr       <= 16'h0000;
            br_total <= 8'h00;
            br_taken <= 8'h00;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ex_pc    <= ex_pc_n;
            ex_valid <= ex_valid_n;
            flush    <= flush_n;
            lr       <= lr_n;
            br_total <= br_total_n;
            br_taken <= br_taken_n;
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: reset, sequential run, branches, stall/halt,
// wrap, saturation and reset during FLUSH, checked against hand-computed values.
module tb_pc_branch_unit;

    localparam logic [15:0] S_RUN   = 16'd0;
    localparam logic [15:0] S_FLUSH = 16'd1;
    localparam logic [15:0] S_HALT  = 16'd2;

    logic        clk;
    logic        rst;
    logic        F;
    logic        br_req;
    logic        br_link;
    logic [15:0] br_imm;
    logic        stall;
    logic        halt;
    logic [15:0] pc;
    logic [15:0] ex_pc;
    logic        ex_valid;
    logic        flush;
    logic [15:0] lr;
    logic [7:0]  br_total;
    logic [7:0]  br_taken;
    logic [1:0]  fsm_state;

    int pass_cnt;
    int total_cnt;

    pc_branch_unit #(.RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .F         (F),
        .br_req    (br_req),
        .br_link   (br_link),
        .br_imm    (br_imm),
        .stall     (stall),
        .halt      (halt),
        .pc        (pc),
        .ex_pc     (ex_pc),
        .ex_valid  (ex_valid),
        .flush     (flush),
        .lr        (lr),
        .br_total  (br_total),
        .br_taken  (br_taken),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one rising edge, then settle before sampling
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [15:0] e_pc, input logic [15:0] e_ex_pc,
                           input logic e_valid, input logic e_flush, input logic [15:0] e_lr,
                           input logic [7:0] e_total, input logic [7:0] e_taken,
                           input logic [15:0] e_state);
        chk({tag, ".pc"},       pc,                   e_pc);
        chk({tag, ".ex_pc"},    ex_pc,                e_ex_pc);
        chk({tag, ".ex_valid"}, {15'd0, ex_valid},    {15'd0, e_valid});
        chk({tag, ".flush"},    {15'd0, flush},       {15'd0, e_flush});
        chk({tag, ".lr"},       lr,                   e_lr);
        chk({tag, ".br_total"}, {8'd0, br_total},     {8'd0, e_total});
        chk({tag, ".br_taken"}, {8'd0, br_taken},     {8'd0, e_taken});
        chk({tag, ".state"},    {14'd0, fsm_state},   e_state);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst = 1'b1; F = 1'b0; br_req = 1'b0; br_link = 1'b0;
        br_imm = 16'h0000; stall = 1'b0; halt = 1'b0;

        // reset state
        step(1);
        chk_all("reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'd0, 8'd0, S_RUN);

        // sequential run of 4 cycles
        rst = 1'b0;
        step(1);
        chk_all("first_edge", 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h0000, 8'd0, 8'd0, S_RUN);
        step(3);
        chk_all("seq4", 16'h0004, 16'h0003, 1'b1, 1'b0, 16'h0000, 8'd0, 8'd0, S_RUN);

        // not-taken branch at ex_pc=5
        step(2);
        chk("nt_pre.ex_pc", ex_pc, 16'h0005);
        br_req = 1'b1; F = 1'b0; br_imm = 16'h0040;
        step(1);
        br_req = 1'b0;
        chk_all("not_taken", 16'h0007, 16'h0006, 1'b1, 1'b0, 16'h0000, 8'd1, 8'd0, S_RUN);

        // taken branch with link at ex_pc=0x10, offset -16
        step(10);
        chk("tk_pre.ex_pc", ex_pc, 16'h0010);
        br_req = 1'b1; F = 1'b1; br_link = 1'b1; br_imm = 16'hFFF0;
        step(1);
        br_req = 1'b0; F = 1'b0; br_link = 1'b0;
        chk_all("taken_link", 16'h0000, 16'h0010, 1'b0, 1'b1, 16'h0011, 8'd2, 8'd1, S_FLUSH);
        step(1);
        chk_all("taken_refill", 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h0011, 8'd2, 8'd1, S_RUN);

        // stall for 3 cycles with a live taken branch request: nothing moves
        br_req = 1'b1; F = 1'b1; br_link = 1'b1; br_imm = 16'h0005; stall = 1'b1;
        step(1);
        chk_all("stall1", 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h0011, 8'd2, 8'd1, S_RUN);
        step(1);
        chk_all("stall2", 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h0011, 8'd2, 8'd1, S_RUN);
        step(1);
        chk_all("stall3", 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h0011, 8'd2, 8'd1, S_RUN);

        // release stall: taken branch without link, then stall inside FLUSH
        stall = 1'b0; br_link = 1'b0;
        step(1);
        br_req = 1'b0; F = 1'b0;
        chk_all("taken_nolink", 16'h0005, 16'h0000, 1'b0, 1'b1, 16'h0011, 8'd3, 8'd2, S_FLUSH);
        stall = 1'b1;
        step(1);
        chk_all("stall_in_flush", 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h0011, 8'd3, 8'd2, S_FLUSH);
        stall = 1'b0;
        step(1);
        chk_all("flush_exit", 16'h0006, 16'h0005, 1'b1, 1'b0, 16'h0011, 8'd3, 8'd2, S_RUN);

        // halt together with stall, then HALT is sticky and ignores branches
        halt = 1'b1; stall = 1'b1; br_req = 1'b1; F = 1'b1;
        step(1);
        chk_all("halt", 16'h0006, 16'h0005, 1'b0, 1'b0, 16'h0011, 8'd3, 8'd2, S_HALT);
        halt = 1'b0; stall = 1'b0;
        step(2);
        chk_all("halt_sticky", 16'h0006, 16'h0005, 1'b0, 1'b0, 16'h0011, 8'd3, 8'd2, S_HALT);
        br_req = 1'b0; F = 1'b0;

        // fresh reset, branch to 0xFFFF with offset -1, then pc wraps to 0
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        br_req = 1'b1; F = 1'b1; br_link = 1'b1; br_imm = 16'hFFFF;
        step(1);
        br_req = 1'b0;
        chk_all("neg_target", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0001, 8'd1, 8'd1, S_FLUSH);
        step(1);
        chk_all("pc_wrap", 16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'h0001, 8'd1, 8'd1, S_RUN);
        br_req = 1'b1; br_imm = 16'h0002;
        step(1);
        chk_all("lr_wrap", 16'h0001, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 8'd2, 8'd2, S_FLUSH);

        // back-to-back taken branches (offset 0) to saturate both counters
        br_imm = 16'h0000;
        step(600);
        chk_all("saturate", 16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 8'hFF, 8'hFF, S_FLUSH);
        step(1);
        F = 1'b0;
        step(1);
        chk("sat_nt.br_total", {8'd0, br_total}, 16'h00FF);
        chk("sat_nt.br_taken", {8'd0, br_taken}, 16'h00FF);
        F = 1'b1;
        step(1);
        chk("sat_tk.state", {14'd0, fsm_state}, S_FLUSH);

        // reset in the FLUSH cycle overrides halt, stall and the pending refill
        rst = 1'b1; halt = 1'b1; stall = 1'b1;
        step(1);
        rst = 1'b0; halt = 1'b0; stall = 1'b0; br_req = 1'b0; F = 1'b0;
        chk_all("rst_mid_flush", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'd0, 8'd0, S_RUN);
        step(1);
        chk_all("after_rst", 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h0000, 8'd0, 8'd0, S_RUN);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
